// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - control/branch request and PC status bundle for pc_unit
interface pc_unit_if #(
  parameter int ADDR_W = 8
);
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_off;
  logic              jump;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_next;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_err;

  modport master (
    output stall, branch_taken, branch_off, jump, call, ret, jump_target,
    input  pc_out, pc_next, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  stall, branch_taken, branch_off, jump, call, ret, jump_target,
    output pc_out, pc_next, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with next-PC select and circular return-address stack
module pc_unit #(
  parameter int ADDR_W    = 8,
  parameter int STEP      = 4,
  parameter int RESET_VEC = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  pc_unit_if.slave bus
);
  localparam int                PTR_W    = $clog2(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] STEP_V   = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] RESET_V  = ADDR_W'(RESET_VEC);
  localparam logic [PTR_W:0]    CNT_FULL = (PTR_W+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic [PTR_W-1:0]  r_wp;
  logic [PTR_W:0]    r_cnt;
  logic              r_err;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];

  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_pc_next;
  logic [PTR_W-1:0]  w_top_idx;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_err;

  assign w_seq     = r_pc + STEP_V;
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CNT_FULL);
  // r_wp is the next write slot, so the top entry sits just below it
  assign w_top_idx = r_wp - PTR_W'(1);

  always_comb begin
    w_pc_next = w_seq;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_err     = 1'b0;
    if (bus.stall) begin
      w_pc_next = r_pc;
    end else if (bus.ret) begin
      if (!w_empty) begin
        w_pc_next = r_ras[w_top_idx];
        w_pop     = 1'b1;
      end else begin
        w_err = 1'b1;
      end
    end else if (bus.call) begin
      w_pc_next = bus.jump_target;
      w_push    = 1'b1;
      w_err     = w_full;
    end else if (bus.jump) begin
      w_pc_next = bus.jump_target;
    end else if (bus.branch_taken) begin
      w_pc_next = r_pc + bus.branch_off;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc  <= RESET_V;
      r_wp  <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_pc  <= w_pc_next;
      r_err <= w_err;
      if (w_push) begin
        r_wp <= r_wp + PTR_W'(1);
        if (!w_full) r_cnt <= r_cnt + (PTR_W+1)'(1);
      end else if (w_pop) begin
        r_wp  <= w_top_idx;
        r_cnt <= r_cnt - (PTR_W+1)'(1);
      end
    end
  end

  // When full, r_wp already points at the oldest entry, so a push overwrites it
  always_ff @(posedge clk) begin
    if (reset && w_push) r_ras[r_wp] <= w_seq;
  end

  assign bus.pc_out    = r_pc;
  assign bus.pc_next   = w_pc_next;
  assign bus.ras_empty = w_empty;
  assign bus.ras_full  = w_full;
  assign bus.ras_err   = r_err;
endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - vector-table and scoreboard bench for pc_unit
module tb_pc_unit;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pc_unit_if #(.ADDR_W(8)) bus ();

  pc_unit #(
    .ADDR_W(8), .STEP(4), .RESET_VEC(0), .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       stall, ret, call, jump, br;
    logic [7:0] off, tgt;
    logic [7:0] pc;
    logic       err, emp, full;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] pc;
    logic       err, emp, full;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(logic s, logic r, logic c, logic j, logic b,
                              logic [7:0] off, logic [7:0] tgt, logic [7:0] pc,
                              logic err, logic emp, logic full);
    vec_t v;
    v.stall = s; v.ret = r; v.call = c; v.jump = j; v.br = b;
    v.off = off; v.tgt = tgt; v.pc = pc; v.err = err; v.emp = emp; v.full = full;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(logic s, logic r, logic c, logic j, logic b,
                       logic [7:0] off, logic [7:0] tgt);
    bus.stall = s; bus.ret = r; bus.call = c; bus.jump = j; bus.branch_taken = b;
    bus.branch_off = off; bus.jump_target = tgt;
  endtask

  initial begin
    exp_t e;
    checks = 0;
    errors = 0;
    //          s  r  c  j  b  off    tgt  pc   err emp full
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,  8'd0,   8'd4,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,  8'd0,   8'd8,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,  8'd0,   8'd12,  0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,  8'd0,   8'd16,  0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'd0,  8'd8,   8'd8,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 8'hF8, 8'd0,   8'd0,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'd0,  8'd252, 8'd252, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,  8'd0,   8'd0,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'd0,  8'd20,  8'd20,  0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 8'd16, 8'd100, 8'd20,  0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 8'd16, 8'd100, 8'd24,  1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,  8'd0,   8'd28,  0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'd0,  8'd0,   8'd0,   0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'd0,  8'd40,  8'd40,  0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'd0,  8'd80,  8'd80,  0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'd0,  8'd120, 8'd120, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'd0,  8'd0,   8'd84,  0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'd0,  8'd0,   8'd44,  0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'd0,  8'd0,   8'd4,   0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 8'd0,  8'd0,   8'd0,   0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'd0,  8'd40,  8'd40,  0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'd0,  8'd80,  8'd80,  0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'd0,  8'd120, 8'd120, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'd0,  8'd160, 8'd160, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 8'd0,  8'd200, 8'd200, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'd0,  8'd0,   8'd164, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'd0,  8'd0,   8'd124, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'd0,  8'd0,   8'd84,  0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'd0,  8'd0,   8'd44,  0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 8'd0,  8'd0,   8'd48,  1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 8'd0,  8'd0,   8'd52,  0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 8'd0,  8'd60,  8'd60,  0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 8'd0,  8'd200, 8'd56,  0, 1, 0));

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 8'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", bus.pc_out, 0);
    chk("reset_empty", bus.ras_empty, 1);
    chk("reset_full", bus.ras_full, 0);
    chk("reset_err", bus.ras_err, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].stall, vecs[i].ret, vecs[i].call, vecs[i].jump, vecs[i].br,
            vecs[i].off, vecs[i].tgt);
      e.idx = i; e.pc = vecs[i].pc; e.err = vecs[i].err;
      e.emp = vecs[i].emp; e.full = vecs[i].full;
      sb.push_back(e);
      #1;
      chk($sformatf("v%0d_pc_next", i), bus.pc_next, vecs[i].pc);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 0, 1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_pc_out", e.idx), bus.pc_out, e.pc);
        chk($sformatf("v%0d_ras_err", e.idx), bus.ras_err, e.err);
        chk($sformatf("v%0d_ras_empty", e.idx), bus.ras_empty, e.emp);
        chk($sformatf("v%0d_ras_full", e.idx), bus.ras_full, e.full);
      end
      @(negedge clk);
    end
    chk("scoreboard_drained", sb.size(), 0);

    // Async reset while a call is pending: PC at 56, RAS empty
    drive(0, 0, 1, 0, 0, 8'd0, 8'd80);
    @(posedge clk);
    #1;
    chk("ar_call_pc", bus.pc_out, 80);
    chk("ar_call_nonempty", bus.ras_empty, 0);
    @(negedge clk);
    drive(0, 0, 1, 0, 0, 8'd0, 8'd120);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_pc_immediate", bus.pc_out, 0);
    chk("ar_empty_immediate", bus.ras_empty, 1);
    chk("ar_err_immediate", bus.ras_err, 0);
    @(posedge clk);
    #1;
    chk("ar_pc_held", bus.pc_out, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 8'd0, 8'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("ar_release_pc", bus.pc_out, 4);
    chk("ar_release_empty", bus.ras_empty, 1);
    @(negedge clk);
    drive(0, 1, 0, 0, 0, 8'd0, 8'd0);
    @(posedge clk);
    #1;
    chk("ar_ret_underflow_pc", bus.pc_out, 8);
    chk("ar_ret_underflow_err", bus.ras_err, 1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 8'd0, 8'd0);
    @(posedge clk);
    #1;
    chk("ar_err_clears", bus.ras_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
